// File: rtl/hex_fragment_serializer.sv
// ============================================================================
// Module   : hex_fragment_serializer
// Buffers rasterizer batches in a slot ring, culls off-grid fragments and
// streams survivors one per cycle with a linear tile address.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hex_fragment_serializer #(
    parameter int BATCH  = 10,
    parameter int SLOTS  = 2,
    parameter int GRID_W = 64,
    parameter int GRID_H = 64,
    parameter int ADDR_W = $clog2(GRID_W * GRID_H)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic [16*BATCH-1:0]      q,
    input  logic [16*BATCH-1:0]      r,
    input  logic [8*BATCH-1:0]       depth,
    output logic                     full,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [15:0]       out_q,
    output logic signed [15:0]       out_r,
    output logic [7:0]               out_depth,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     out_last,
    output logic                     overflow,
    output logic [15:0]              drop_count
);

    localparam int IDX_W = (BATCH > 1) ? $clog2(BATCH) : 1;
    localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CNT_W = $clog2(SLOTS + 1);

    logic [16*BATCH-1:0] slot_q_q     [SLOTS];
    logic [16*BATCH-1:0] slot_r_q     [SLOTS];
    logic [8*BATCH-1:0]  slot_d_q     [SLOTS];
    logic [BATCH-1:0]    slot_mask_q  [SLOTS];
    logic [IDX_W-1:0]    slot_last_q  [SLOTS];

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic               out_valid_q, out_valid_d;
    logic signed [15:0] out_q_q, out_q_d;
    logic signed [15:0] out_r_q, out_r_d;
    logic [7:0]         out_depth_q, out_depth_d;
    logic [ADDR_W-1:0]  out_addr_q, out_addr_d;
    logic               out_last_q, out_last_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        drop_count_q, drop_count_d;

    logic [BATCH-1:0]   w_mask;
    logic [IDX_W-1:0]   w_lastidx;
    logic               w_acc, w_ovf, w_adv, w_rel, w_cull, w_el_m;
    logic signed [15:0] w_el_q, w_el_r;
    logic [7:0]         w_el_d;
    logic [16:0]        w_drop_sum;

    function automatic logic in_grid(input logic signed [15:0] qq,
                                     input logic signed [15:0] rr);
        return (int'(qq) >= 0) && (int'(qq) < GRID_W) &&
               (int'(rr) >= 0) && (int'(rr) < GRID_H);
    endfunction

    always_comb begin
        w_mask    = '0;
        w_lastidx = '0;
        for (int i = 0; i < BATCH; i++) begin
            w_mask[i] = in_grid(q[16*i +: 16], r[16*i +: 16]);
            if (w_mask[i]) begin
                w_lastidx = IDX_W'(i);
            end
        end
    end

    // Capture only sees the registered count: a same-cycle release frees nothing.
    assign w_acc  = valid_in && (count_q < CNT_W'(SLOTS));
    assign w_ovf  = valid_in && !w_acc;
    assign w_adv  = (count_q != '0) && (!out_valid_q || out_ready);
    assign w_rel  = w_adv && (idx_q == IDX_W'(BATCH - 1));
    assign w_el_m = slot_mask_q[rd_ptr_q][idx_q];
    assign w_el_q = slot_q_q[rd_ptr_q][16*int'(idx_q) +: 16];
    assign w_el_r = slot_r_q[rd_ptr_q][16*int'(idx_q) +: 16];
    assign w_el_d = slot_d_q[rd_ptr_q][8*int'(idx_q) +: 8];
    assign w_cull = w_adv && !w_el_m;

    assign w_drop_sum = {1'b0, drop_count_q} + 17'(w_cull)
                      + (w_ovf ? 17'(BATCH) : 17'd0);

    always_comb begin
        count_d      = count_q + CNT_W'(w_acc) - CNT_W'(w_rel);
        wr_ptr_d     = wr_ptr_q + PTR_W'(w_acc);
        rd_ptr_d     = rd_ptr_q + PTR_W'(w_rel);
        idx_d        = idx_q;
        overflow_d   = overflow_q || w_ovf;
        drop_count_d = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        out_valid_d  = out_valid_q;
        out_q_d      = out_q_q;
        out_r_d      = out_r_q;
        out_depth_d  = out_depth_q;
        out_addr_d   = out_addr_q;
        out_last_d   = out_last_q;

        if (w_adv) begin
            idx_d = w_rel ? '0 : idx_q + IDX_W'(1);
            if (w_el_m) begin
                out_valid_d = 1'b1;
                out_q_d     = w_el_q;
                out_r_d     = w_el_r;
                out_depth_d = w_el_d;
                out_addr_d  = ADDR_W'(w_el_r) * ADDR_W'(GRID_W) + ADDR_W'(w_el_q);
                out_last_d  = (idx_q == slot_last_q[rd_ptr_q]);
            end else begin
                out_valid_d = 1'b0;
            end
        end else if ((count_q == '0) && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SLOTS; s++) begin
                slot_q_q[s]    <= '0;
                slot_r_q[s]    <= '0;
                slot_d_q[s]    <= '0;
                slot_mask_q[s] <= '0;
                slot_last_q[s] <= '0;
            end
        end else if (w_acc) begin
            slot_q_q[wr_ptr_q]    <= q;
            slot_r_q[wr_ptr_q]    <= r;
            slot_d_q[wr_ptr_q]    <= depth;
            slot_mask_q[wr_ptr_q] <= w_mask;
            slot_last_q[wr_ptr_q] <= w_lastidx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            idx_q        <= '0;
            out_valid_q  <= 1'b0;
            out_q_q      <= '0;
            out_r_q      <= '0;
            out_depth_q  <= '0;
            out_addr_q   <= '0;
            out_last_q   <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            idx_q        <= idx_d;
            out_valid_q  <= out_valid_d;
            out_q_q      <= out_q_d;
            out_r_q      <= out_r_d;
            out_depth_q  <= out_depth_d;
            out_addr_q   <= out_addr_d;
            out_last_q   <= out_last_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign full       = (count_q == CNT_W'(SLOTS));
    assign out_valid  = out_valid_q;
    assign out_q      = out_q_q;
    assign out_r      = out_r_q;
    assign out_depth  = out_depth_q;
    assign out_addr   = out_addr_q;
    assign out_last   = out_last_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

`default_nettype wire

// File: tb/tb_hex_fragment_serializer.sv
// ============================================================================
// Module   : tb_hex_fragment_serializer
// Directed, table-driven bench for hex_fragment_serializer.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hex_fragment_serializer;

    localparam int BATCH = 10;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  valid_in = 1'b0;
    logic                  out_ready = 1'b1;
    logic [16*BATCH-1:0]   q_in = '0;
    logic [16*BATCH-1:0]   r_in = '0;
    logic [8*BATCH-1:0]    d_in = '0;
    logic                  full, out_valid, out_last, overflow;
    logic signed [15:0]    out_q, out_r;
    logic [7:0]            out_depth;
    logic [11:0]           out_addr;
    logic [15:0]           drop_count;

    hex_fragment_serializer dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .q          (q_in),
        .r          (r_in),
        .depth      (d_in),
        .full       (full),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_q      (out_q),
        .out_r      (out_r),
        .out_depth  (out_depth),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] q;
        logic signed [15:0] r;
        logic [7:0]         d;
        logic               ev;
        logic [11:0]        ea;
        logic               el;
    } vec_t;

    vec_t tbl [BATCH];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_basic(input int rr);
        for (int i = 0; i < BATCH; i++) begin
            tbl[i].q  = 16'(i);
            tbl[i].r  = 16'(rr);
            tbl[i].d  = 8'(i);
            tbl[i].ev = 1'b1;
            tbl[i].ea = 12'(rr * 64 + i);
            tbl[i].el = (i == BATCH - 1);
        end
    endtask

    task automatic fill_cull();
        fill_basic(2);
        tbl[3].q  = -16'sd1;
        tbl[3].ev = 1'b0;
        tbl[7].r  = 16'sd64;
        tbl[7].ev = 1'b0;
        tbl[9].q  = 16'sd64;
        tbl[9].ev = 1'b0;
        tbl[9].el = 1'b0;
        tbl[8].el = 1'b1;
    endtask

    task automatic pack();
        for (int i = 0; i < BATCH; i++) begin
            q_in[16*i +: 16] = tbl[i].q;
            r_in[16*i +: 16] = tbl[i].r;
            d_in[8*i +: 8]   = tbl[i].d;
        end
    endtask

    task automatic capture();
        pack();
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < BATCH; i++) begin
            step();
            chk($sformatf("%s valid[%0d]", tag, i), 32'(out_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("%s q[%0d]", tag, i),     32'(out_q),     32'(tbl[i].q));
                chk($sformatf("%s addr[%0d]", tag, i),  32'(out_addr),  32'(tbl[i].ea));
                chk($sformatf("%s depth[%0d]", tag, i), 32'(out_depth), 32'(tbl[i].d));
                chk($sformatf("%s last[%0d]", tag, i),  32'(out_last),  32'(tbl[i].el));
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst out_q", 32'(out_q), 0);
        chk("rst out_addr", 32'(out_addr), 0);
        chk("rst drop_count", 32'(drop_count), 0);
        chk("rst overflow", 32'(overflow), 0);
        chk("rst full", 32'(full), 0);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        step();
        step();
        chk("init out_valid", 32'(out_valid), 0);
        chk("init out_last", 32'(out_last), 0);
        chk("init full", 32'(full), 0);
        chk("init overflow", 32'(overflow), 0);
        chk("init drop_count", 32'(drop_count), 0);
        reset = 1'b0;
        step();

        // Clean batch streams back-to-back starting the cycle after capture.
        fill_basic(2);
        capture();
        chk("t1 valid at capture", 32'(out_valid), 0);
        run_table("t1");
        step();
        chk("t1 valid after", 32'(out_valid), 0);
        chk("t1 drop", 32'(drop_count), 0);

        fill_cull();
        capture();
        run_table("t2");
        chk("t2 drop", 32'(drop_count), 3);

        // Backpressure while beat 4 is presented.
        do_reset();
        fill_basic(2);
        capture();
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("t3 pre q[%0d]", i), 32'(out_q), 32'(i));
        end
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3 stall valid", 32'(out_valid), 1);
            chk("t3 stall q", 32'(out_q), 4);
            chk("t3 stall addr", 32'(out_addr), 132);
        end
        out_ready = 1'b1;
        for (int i = 5; i < BATCH; i++) begin
            step();
            chk($sformatf("t3 post q[%0d]", i), 32'(out_q), 32'(i));
            chk($sformatf("t3 post last[%0d]", i), 32'(out_last), 32'(i == BATCH - 1));
        end
        step();
        chk("t3 valid after", 32'(out_valid), 0);

        // Three consecutive batches into a two-slot ring with no drain.
        do_reset();
        out_ready = 1'b0;
        valid_in  = 1'b1;
        fill_basic(2);
        pack();
        step();
        chk("t4 full after 1", 32'(full), 0);
        fill_basic(5);
        pack();
        step();
        chk("t4 full after 2", 32'(full), 1);
        fill_basic(10);
        pack();
        step();
        valid_in = 1'b0;
        chk("t4 overflow", 32'(overflow), 1);
        chk("t4 drop", 32'(drop_count), 10);
        chk("t4 head valid", 32'(out_valid), 1);
        chk("t4 head addr", 32'(out_addr), 128);
        out_ready = 1'b1;
        for (int i = 1; i < BATCH; i++) begin
            step();
            chk($sformatf("t4 A addr[%0d]", i), 32'(out_addr), 32'(128 + i));
            chk($sformatf("t4 A full[%0d]", i), 32'(full), 32'(i != BATCH - 1));
        end
        for (int i = 0; i < BATCH; i++) begin
            step();
            chk($sformatf("t4 B valid[%0d]", i), 32'(out_valid), 1);
            chk($sformatf("t4 B addr[%0d]", i), 32'(out_addr), 32'(320 + i));
        end
        step();
        chk("t4 valid after", 32'(out_valid), 0);
        chk("t4 drop after", 32'(drop_count), 10);
        chk("t4 overflow sticky", 32'(overflow), 1);

        // Fully culled batch followed by a valid one.
        do_reset();
        for (int i = 0; i < BATCH; i++) begin
            tbl[i].q = 16'sd100;
            tbl[i].r = 16'sd0;
            tbl[i].d = 8'd0;
        end
        pack();
        valid_in = 1'b1;
        step();
        fill_basic(3);
        pack();
        step();
        valid_in = 1'b0;
        chk("t5 bubble 0", 32'(out_valid), 0);
        for (int k = 1; k < BATCH; k++) begin
            step();
            chk($sformatf("t5 bubble %0d", k), 32'(out_valid), 0);
        end
        chk("t5 drop", 32'(drop_count), 10);
        run_table("t5");

        // Asynchronous reset mid-stream.
        do_reset();
        fill_cull();
        capture();
        for (int i = 0; i < 6; i++) step();
        chk("t6 beat5 q", 32'(out_q), 5);
        chk("t6 drop before", 32'(drop_count), 1);
        do_reset();
        fill_basic(2);
        capture();
        chk("t6 valid at capture", 32'(out_valid), 0);
        run_table("t6");
        chk("t6 drop", 32'(drop_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hex_fragment_serializer.md
Name: hex_fragment_serializer

Overview:
- Downstream consumer of the Q16.16 hexagonal rasterizer.
- Captures each BATCH-wide result (q, r, depth) on its valid pulse into a small ring of batch slots.
- Culls fragments outside the hex grid and computes a linear tile address.
- Streams surviving fragments one per cycle on a valid/ready interface to the depth/tile write stage.

Parameters:
- BATCH, 10, fragments per input batch; must equal the rasterizer's BATCH.
- SLOTS, 2, batch slots buffered (power of two, ≥2).
- GRID_W, 64, grid width in q (columns).
- GRID_H, 64, grid height in r (rows).
- ADDR_W, $clog2(GRID_W*GRID_H), tile address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  1  one-cycle batch strobe from the rasterizer.
- q  in  16 signed x BATCH  axial q per fragment.
- r  in  16 signed x BATCH  axial r per fragment.
- depth  in  8 x BATCH  fragment depth.
- full  out  1  all SLOTS occupied (count==SLOTS).
- out_valid  out  1  fragment present on outputs.
- out_ready  in  1  downstream accepts.
- out_q  out  16 signed  fragment q.
- out_r  out  16 signed  fragment r.
- out_depth  out  8  fragment depth.
- out_addr  out  ADDR_W  r*GRID_W+q.
- out_last  out  1  highest-indexed surviving fragment of its batch.
- overflow  out  1  sticky: a batch was dropped because the ring was full.
- drop_count  out  16  saturating count of culled plus overflow-dropped fragments.

Behaviour:
- Reset is asynchronous and active-high. While asserted: all outputs 0, count/wr_ptr/rd_ptr/idx 0, all slot contents invalid. A reset mid-stream discards every buffered fragment and clears overflow and drop_count.
- Capture:
  - Sampled on a clk edge with valid_in=1.
  - Accepted iff registered count<SLOTS; a release in the same cycle does not free space for this capture.
  - On accept: store q/r/depth into slot[wr_ptr], wr_ptr++ (mod SLOTS).
  - On accept: store mask[i] = (0≤q[i]<GRID_W)&&(0≤r[i]<GRID_H), signed compares.
  - On accept: store lastidx = highest set bit of mask.
- Overflow: valid_in while count==SLOTS drops the batch, sets overflow (sticky), and adds BATCH to drop_count.
- Read engine:
  - Advances when slot count>0 and (out_valid==0 or out_ready==1).
  - Examines element idx of slot[rd_ptr]:
    - If mask[idx]=1: load output regs, out_valid=1, out_last=(idx==lastidx), out_addr=r*GRID_W+q truncated to ADDR_W.
    - If mask[idx]=0: out_valid=0 and drop_count+1.
  - idx==BATCH-1: release slot (rd_ptr++, count--), idx=0; else idx++.
  - When the engine cannot advance, outputs hold stable.
  - When no slot is pending and the output is accepted, out_valid goes to 0.
- Latency and throughput:
  - Capture at edge N; element 0 appears at edge N+1.
  - With out_ready=1: one element examined per cycle, no bubbles between batches.
  - A culled element costs one bubble cycle.
- Simultaneous events:
  - Capture and release in the same cycle leave count unchanged.
  - A cull increment and an overflow increment in the same cycle are summed, then saturated at 0xFFFF.
- All-culled batch: no out_valid for BATCH cycles, drop_count+=BATCH, then the slot is released.
- Order: fragments exit in batch order, then index order.

Test Plan:
- Single batch q[i]=i, r[i]=2, depth[i]=i, out_ready=1 -> 10 consecutive beats from the cycle after capture; out_addr=128+i; out_last only at i=9; drop_count=0.
- Same batch with q[3]=-1, r[7]=64, q[9]=64 -> 7 beats (i=0,1,2,4,5,6,8); bubbles at 3,7,9; out_last at i=8; drop_count=3.
- out_ready=0 for 5 cycles while beat i=4 is presented -> out_q=4, out_addr=132, out_valid=1 held stable; stream resumes with i=5 after ready returns.
- out_ready=0, three valid_in pulses on consecutive cycles -> first two accepted; full=1 after the second; third dropped; overflow=1; drop_count=10. Then out_ready=1 -> 20 beats in order, full deasserts after the first batch drains.
- Batch with all q=100, then a valid batch -> no out_valid for 10 cycles, drop_count=10, then 10 beats of the second batch.
- reset pulsed mid-stream at beat 5 -> all outputs 0 immediately (asynchronous). After release, the next batch streams from i=0 with drop_count=0.
